// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares the single synchronous video-RAM port among the sprite fetcher
//   (SPR), the background tile fetcher (BG) and the CPU bridge (CPU, the only
//   writer). One access is issued per cycle at most. Each read is tagged with
//   its owner, and the owner's rvalid is raised when the RAM data returns
//   RD_LAT cycles later.
//
//   Priority: SPR > BG > CPU during active video. The order switches to
//   CPU > SPR > BG during vblank, and also once the CPU has been blocked for
//   CPU_MAX_WAIT cycles.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   vblank                        high outside the visible region
//   spr_req/addr, spr_gnt         sprite read request / issued strobe
//   spr_rvalid                    rdata belongs to the sprite fetcher
//   bg_req/addr, bg_gnt           background read request / issued strobe
//   bg_rvalid                     rdata belongs to the BG fetcher
//   cpu_req/we/addr/wdata         CPU request (read or write)
//   cpu_gnt, cpu_rvalid           CPU issued strobe / read data valid
//   mem_en/we/addr/wdata          registered RAM command
//   mem_rdata                     RAM read data
//   rdata                         shared read-data bus (copy of mem_rdata)
// ---------------------------------------------------------------------------
module vram_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 16,
   parameter int RD_LAT       = 2,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vblank,
   input  logic              spr_req,
   input  logic [ADDR_W-1:0] spr_addr,
   output logic              spr_gnt,
   output logic              spr_rvalid,
   input  logic              bg_req,
   input  logic [ADDR_W-1:0] bg_addr,
   output logic              bg_gnt,
   output logic              bg_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

   typedef enum logic [1:0] {
      ID_SPR = 2'd0,
      ID_BG  = 2'd1,
      ID_CPU = 2'd2
   } client_e;

   typedef struct packed {
      logic    valid;
      client_e id;
   } tag_t;

   // Registered command / grant state
   logic              spr_gnt_q, bg_gnt_q, cpu_gnt_q;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;

   // Arbitration decision for the next edge
   logic spr_elig, bg_elig, cpu_elig, cpu_first;
   logic sel_spr, sel_bg, sel_cpu;

   // Read-return tag pipeline; the last stage owns the current mem_rdata
   tag_t              tag_in;
   tag_t              tag_out;
   tag_t [RD_LAT-1:0] tag_q;

   // A client just granted sits out one cycle, so the requester has time to
   // drop its level request or present the next one.
   assign spr_elig  = spr_req & ~spr_gnt_q;
   assign bg_elig   = bg_req  & ~bg_gnt_q;
   assign cpu_elig  = cpu_req & ~cpu_gnt_q;
   assign cpu_first = vblank | (cpu_wait_q == WAIT_MAX);

   // NOTE: every always_comb output is assigned a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      sel_spr = 1'b0;
      sel_bg  = 1'b0;
      sel_cpu = 1'b0;
      if (cpu_first) begin
         if (cpu_elig)      sel_cpu = 1'b1;
         else if (spr_elig) sel_spr = 1'b1;
         else if (bg_elig)  sel_bg  = 1'b1;
      end else begin
         if (spr_elig)      sel_spr = 1'b1;
         else if (bg_elig)  sel_bg  = 1'b1;
         else if (cpu_elig) sel_cpu = 1'b1;
      end
   end

   // Address and write data hold their last value while the port is idle.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (sel_spr) mem_addr_d = spr_addr;
      if (sel_bg)  mem_addr_d = bg_addr;
      if (sel_cpu) begin
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
      end
   end

   // Starvation counter: counts edges on which the CPU asks but loses, and
   // saturates so the CPU keeps top priority until it is actually picked.
   always_comb begin
      cpu_wait_d = '0;
      if (cpu_req && !sel_cpu) begin
         cpu_wait_d = (cpu_wait_q == WAIT_MAX) ? cpu_wait_q
                                               : cpu_wait_q + WAIT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spr_gnt_q   <= 1'b0;
         bg_gnt_q    <= 1'b0;
         cpu_gnt_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_wait_q  <= '0;
      end else begin
         spr_gnt_q   <= sel_spr;
         bg_gnt_q    <= sel_bg;
         cpu_gnt_q   <= sel_cpu;
         mem_en_q    <= sel_spr | sel_bg | sel_cpu;
         mem_we_q    <= sel_cpu & cpu_we;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_wait_q  <= cpu_wait_d;
      end
   end

   // The tag enters at the end of the grant cycle; after RD_LAT-1 more shifts
   // it reaches the last stage exactly when the RAM presents the data.
   always_comb begin
      tag_in.valid = mem_en_q & ~mem_we_q;
      tag_in.id    = cpu_gnt_q ? ID_CPU : (bg_gnt_q ? ID_BG : ID_SPR);
   end

   // NOTE: the tag pipeline is reset, unlike a data-only delay line, because
   // its valid bits must not produce a return for a read lost to reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_q[i] <= tag_q[i-1];
         end
         tag_q[0] <= tag_in;
      end
   end

   assign tag_out    = tag_q[RD_LAT-1];
   assign spr_rvalid = tag_out.valid & (tag_out.id == ID_SPR);
   assign bg_rvalid  = tag_out.valid & (tag_out.id == ID_BG);
   assign cpu_rvalid = tag_out.valid & (tag_out.id == ID_CPU);

   assign spr_gnt   = spr_gnt_q;
   assign bg_gnt    = bg_gnt_q;
   assign cpu_gnt   = cpu_gnt_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = mem_rdata;

endmodule
